// File: rtl/mem_ring_slave.sv
// Memory ring station: decodes Address/WriteData slots, ping-pong write buffers, read FIFO, line-burst command FSM.
// Optional protocol error counter is built only when MEM_RING_ERRCNT_EN is defined.
module mem_ring_slave #(
  parameter int RQ_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] RingIn,
  input  logic [3:0]  SlotTypeIn,
  input  logic [3:0]  SourceIn,
  output logic [31:0] RingOut,
  output logic [3:0]  SlotTypeOut,
  output logic [3:0]  SourceOut,
  output logic [31:0] RDreturn,
  output logic [3:0]  RDdest,
  output logic        memCmdValid,
  input  logic        memCmdReady,
  output logic        memCmdWrite,
  output logic [27:0] memCmdAddr,
  output logic [31:0] memWData,
  input  logic        memWReady,
  input  logic [31:0] memRData,
  input  logic        memRValid,
  output logic [7:0]  errCount
);
  localparam int AW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam logic [3:0] SLOT_NULL  = 4'd7;
  localparam logic [3:0] SLOT_ADDR  = 4'd2;
  localparam logic [3:0] SLOT_WDATA = 4'd3;

  typedef enum logic [2:0] {S_IDLE, S_WCMD, S_WDATA, S_RCMD, S_RDATA} state_t;

  state_t            r_state;
  logic [2:0]        r_beat;
  logic              r_wrd;
  logic [31:0]       r_rdret;
  logic [3:0]        r_rddest;
  logic [31:0]       r_wbuf [2][8];
  logic [27:0]       r_waddr [2];
  logic [1:0]        r_wpend;
  logic              r_wact;
  logic [3:0]        r_wcnt;
  logic [31:0]       r_rq [RQ_DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [AW:0]       r_rq_cnt;

  logic        w_is_addr, w_is_wd, w_rd_req, w_wr_req, w_rq_full, w_push, w_pop;
  logic        w_act_pend, w_wd_ok, w_commit, w_wfree;
  logic [3:0]  w_code;
  logic [31:0] w_head;

  assign w_is_addr  = (SlotTypeIn == SLOT_ADDR);
  assign w_is_wd    = (SlotTypeIn == SLOT_WDATA);
  assign w_code     = RingIn[31:28];
  assign w_rd_req   = w_is_addr && (w_code == 4'b0001 || w_code == 4'b0011);
  assign w_wr_req   = w_is_addr && (w_code == 4'b0000);
  assign w_rq_full  = (r_rq_cnt == (AW+1)'(RQ_DEPTH));
  assign w_push     = w_rd_req && !w_rq_full;
  assign w_head     = r_rq[r_rp];
  // Active buffer still pending means both buffers hold uncommitted-to-memory lines.
  assign w_act_pend = r_wpend[r_wact];
  assign w_wd_ok    = w_is_wd && !w_act_pend && !r_wcnt[3];
  assign w_commit   = w_wr_req && !w_act_pend;
  assign w_wfree    = (r_state == S_WDATA) && memWReady && (r_beat == 3'd7);
  assign w_pop      = (r_state == S_RDATA) && memRValid && (r_beat == 3'd7);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      RingOut     <= '0;
      SlotTypeOut <= SLOT_NULL;
      SourceOut   <= '0;
    end else if (w_is_addr || w_is_wd) begin
      RingOut     <= '0;
      SlotTypeOut <= SLOT_NULL;
      SourceOut   <= '0;
    end else begin
      RingOut     <= RingIn;
      SlotTypeOut <= SlotTypeIn;
      SourceOut   <= SourceIn;
    end
  end

  always_ff @(posedge clock) begin
    if (w_wd_ok)  r_wbuf[r_wact][r_wcnt[2:0]] <= RingIn;
    if (w_commit) r_waddr[r_wact] <= RingIn[27:0];
    if (w_push)   r_rq[r_wp] <= {SourceIn, RingIn[27:0]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wpend  <= '0;
      r_wact   <= 1'b0;
      r_wcnt   <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_rq_cnt <= '0;
    end else begin
      if (w_wfree) r_wpend[r_wrd] <= 1'b0;
      if (w_wd_ok) r_wcnt <= r_wcnt + 4'd1;
      if (w_commit) begin
        r_wpend[r_wact] <= 1'b1;
        r_wact          <= ~r_wact;
        r_wcnt          <= '0;
      end
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_rq_cnt <= r_rq_cnt + 1'b1;
        2'b01:   r_rq_cnt <= r_rq_cnt - 1'b1;
        default: r_rq_cnt <= r_rq_cnt;
      endcase
    end
  end

  // Buffers commit and drain in the same alternating order, so r_wrd always names the oldest line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_wrd       <= 1'b0;
      r_rdret     <= '0;
      r_rddest    <= '0;
      memCmdValid <= 1'b0;
      memCmdWrite <= 1'b0;
      memCmdAddr  <= '0;
    end else begin
      r_rdret  <= '0;
      r_rddest <= '0;
      case (r_state)
        S_IDLE: begin
          r_beat <= '0;
          if (r_wpend[r_wrd]) begin
            r_state     <= S_WCMD;
            memCmdValid <= 1'b1;
            memCmdWrite <= 1'b1;
            memCmdAddr  <= r_waddr[r_wrd];
          end else if (r_rq_cnt != '0) begin
            r_state     <= S_RCMD;
            memCmdValid <= 1'b1;
            memCmdWrite <= 1'b0;
            memCmdAddr  <= w_head[27:0];
          end
        end
        S_WCMD, S_RCMD: begin
          if (memCmdReady) begin
            memCmdValid <= 1'b0;
            r_beat      <= '0;
            r_state     <= (r_state == S_WCMD) ? S_WDATA : S_RDATA;
          end
        end
        S_WDATA: begin
          if (memWReady) begin
            r_beat <= r_beat + 3'd1;
            if (r_beat == 3'd7) begin
              r_wrd   <= ~r_wrd;
              r_state <= S_IDLE;
            end
          end
        end
        S_RDATA: begin
          if (memRValid) begin
            r_rdret  <= memRData;
            r_rddest <= w_head[31:28];
            r_beat   <= r_beat + 3'd1;
            if (r_beat == 3'd7) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign memWData = r_wbuf[r_wrd][r_beat];
  assign RDreturn = r_rdret;
  assign RDdest   = r_rddest;

`ifdef MEM_RING_ERRCNT_EN
  logic       w_err;
  logic [7:0] r_errcnt;

  // At most one slot arrives per cycle, so at most one error per cycle.
  assign w_err = (w_is_addr && !(w_rd_req || w_wr_req)) ||
                 (w_rd_req && w_rq_full) ||
                 (w_is_wd && (w_act_pend || r_wcnt[3])) ||
                 (w_wr_req && (w_act_pend || !r_wcnt[3]));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                            r_errcnt <= '0;
    else if (w_err && r_errcnt != 8'hFF)   r_errcnt <= r_errcnt + 8'd1;
  end

  assign errCount = r_errcnt;
`else
  assign errCount = 8'd0;
`endif

endmodule

// File: tb/tb_mem_ring_slave.sv
// Directed bench for mem_ring_slave: pass-through, read burst, write burst, write priority, FIFO overflow, mid-burst reset.
module tb_mem_ring_slave;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] RingIn;
  logic [3:0]  SlotTypeIn, SourceIn;
  logic [31:0] RingOut;
  logic [3:0]  SlotTypeOut, SourceOut;
  logic [31:0] RDreturn;
  logic [3:0]  RDdest;
  logic        memCmdValid, memCmdReady, memCmdWrite;
  logic [27:0] memCmdAddr;
  logic [31:0] memWData;
  logic        memWReady;
  logic [31:0] memRData;
  logic        memRValid;
  logic [7:0]  errCount;

  int checks = 0;
  int errors = 0;

`ifdef MEM_RING_ERRCNT_EN
  localparam logic [7:0] EXP_OVF_ERR = 8'd1;
`else
  localparam logic [7:0] EXP_OVF_ERR = 8'd0;
`endif

  mem_ring_slave #(.RQ_DEPTH(16)) dut (
    .clock(clock), .reset(reset),
    .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
    .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
    .RDreturn(RDreturn), .RDdest(RDdest),
    .memCmdValid(memCmdValid), .memCmdReady(memCmdReady), .memCmdWrite(memCmdWrite),
    .memCmdAddr(memCmdAddr), .memWData(memWData), .memWReady(memWReady),
    .memRData(memRData), .memRValid(memRValid), .errCount(errCount)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_slot(input logic [3:0] t, input logic [31:0] d, input logic [3:0] s);
    SlotTypeIn = t; RingIn = d; SourceIn = s;
    tick();
    SlotTypeIn = 4'd7; RingIn = '0; SourceIn = '0;
  endtask

  task automatic wait_cmd(input string name);
    int n = 0;
    while (!memCmdValid && n < 20) begin tick(); n++; end
    checks++;
    if (memCmdValid !== 1'b1) begin
      errors++;
      $display("FAIL %s: memCmdValid timeout, got %b want 1", name, memCmdValid);
    end
  endtask

  task automatic accept_cmd();
    memCmdReady = 1'b1; tick(); memCmdReady = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (memCmdValid !== 1'b0 || RDdest !== 4'd0 || RDreturn !== 32'd0 || errCount !== 8'd0) begin
      errors++;
      $display("FAIL reset_mem: valid=%b dest=%h ret=%h err=%h want 0", memCmdValid, RDdest, RDreturn, errCount);
    end
    checks++;
    if (SlotTypeOut !== 4'd7 || RingOut !== 32'd0 || SourceOut !== 4'd0) begin
      errors++;
      $display("FAIL reset_ring: type=%h ring=%h src=%h want 7/0/0", SlotTypeOut, RingOut, SourceOut);
    end
  endtask

  task automatic test_passthrough();
    send_slot(4'd1, 32'hDEADBEEF, 4'd6);
    checks++;
    if (SlotTypeOut !== 4'd1 || RingOut !== 32'hDEADBEEF || SourceOut !== 4'd6) begin
      errors++;
      $display("FAIL pass_token: type=%h ring=%h src=%h want 1/deadbeef/6", SlotTypeOut, RingOut, SourceOut);
    end
    send_slot(4'd4, 32'h12345678, 4'd9);
    checks++;
    if (SlotTypeOut !== 4'd4 || RingOut !== 32'h12345678 || SourceOut !== 4'd9) begin
      errors++;
      $display("FAIL pass_rdata: type=%h ring=%h src=%h want 4/12345678/9", SlotTypeOut, RingOut, SourceOut);
    end
  endtask

  task automatic test_read();
    send_slot(4'd2, 32'h10000040, 4'd3);
    checks++;
    if (SlotTypeOut !== 4'd7 || RingOut !== 32'd0) begin
      errors++;
      $display("FAIL read_consume: type=%h ring=%h want 7/0", SlotTypeOut, RingOut);
    end
    wait_cmd("read_cmd");
    checks++;
    if (memCmdWrite !== 1'b0 || memCmdAddr !== 28'h0000040) begin
      errors++;
      $display("FAIL read_cmd_addr: write=%b addr=%h want 0/0000040", memCmdWrite, memCmdAddr);
    end
    accept_cmd();
    for (int i = 0; i < 8; i++) begin
      memRValid = 1'b1; memRData = 32'hA0 + i;
      tick();
      checks++;
      if (RDreturn !== 32'hA0 + i || RDdest !== 4'd3) begin
        errors++;
        $display("FAIL read_beat%0d: ret=%h dest=%h want %h/3", i, RDreturn, RDdest, 32'hA0 + i);
      end
    end
    memRValid = 1'b0;
    tick();
    checks++;
    if (RDdest !== 4'd0 || memCmdValid !== 1'b0) begin
      errors++;
      $display("FAIL read_end: dest=%h valid=%b want 0/0", RDdest, memCmdValid);
    end
  endtask

  task automatic test_write();
    for (int k = 0; k < 8; k++) begin
      send_slot(4'd3, 32'(k + 1), 4'd2);
      checks++;
      if (SlotTypeOut !== 4'd7 || RingOut !== 32'd0) begin
        errors++;
        $display("FAIL wdata_consume%0d: type=%h ring=%h want 7/0", k, SlotTypeOut, RingOut);
      end
    end
    send_slot(4'd2, 32'h00000080, 4'd2);
    wait_cmd("write_cmd");
    tick();
    checks++;
    if (memCmdValid !== 1'b1 || memCmdWrite !== 1'b1 || memCmdAddr !== 28'h80) begin
      errors++;
      $display("FAIL write_cmd_hold: valid=%b write=%b addr=%h want 1/1/80", memCmdValid, memCmdWrite, memCmdAddr);
    end
    accept_cmd();
    memWReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (memWData !== 32'(k + 1)) begin
        errors++;
        $display("FAIL write_beat%0d: wdata=%h want %h", k, memWData, k + 1);
      end
      tick();
    end
    memWReady = 1'b0;
    tick();
    checks++;
    if (memCmdValid !== 1'b0) begin
      errors++;
      $display("FAIL write_end: valid=%b want 0", memCmdValid);
    end
  endtask

  task automatic test_priority();
    for (int k = 0; k < 8; k++) send_slot(4'd3, 32'h101 + k, 4'd4);
    send_slot(4'd2, 32'h00000100, 4'd4);
    send_slot(4'd2, 32'h10000010, 4'd5);
    for (int k = 0; k < 8; k++) send_slot(4'd3, 32'h11 + k, 4'd4);
    send_slot(4'd2, 32'h00000200, 4'd4);
    checks++;
    if (memCmdValid !== 1'b1 || memCmdWrite !== 1'b1 || memCmdAddr !== 28'h100) begin
      errors++;
      $display("FAIL prio_first: valid=%b write=%b addr=%h want 1/1/100", memCmdValid, memCmdWrite, memCmdAddr);
    end
    accept_cmd();
    memWReady = 1'b1; repeat (8) tick(); memWReady = 1'b0;
    wait_cmd("prio_second");
    checks++;
    if (memCmdWrite !== 1'b1 || memCmdAddr !== 28'h200) begin
      errors++;
      $display("FAIL prio_write_first: write=%b addr=%h want 1/200", memCmdWrite, memCmdAddr);
    end
    accept_cmd();
    checks++;
    if (memWData !== 32'h11) begin
      errors++;
      $display("FAIL prio_wdata: wdata=%h want 11", memWData);
    end
    memWReady = 1'b1; repeat (8) tick(); memWReady = 1'b0;
    wait_cmd("prio_read");
    checks++;
    if (memCmdWrite !== 1'b0 || memCmdAddr !== 28'h10) begin
      errors++;
      $display("FAIL prio_read_cmd: write=%b addr=%h want 0/10", memCmdWrite, memCmdAddr);
    end
    accept_cmd();
    memRValid = 1'b1; memRData = 32'h55; tick();
    checks++;
    if (RDdest !== 4'd5 || RDreturn !== 32'h55) begin
      errors++;
      $display("FAIL prio_read_beat: dest=%h ret=%h want 5/55", RDdest, RDreturn);
    end
    repeat (7) tick();
    memRValid = 1'b0;
    tick();
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 17; i++) send_slot(4'd2, {4'h1, 28'(i)}, 4'((i % 15) + 1));
    checks++;
    if (errCount !== EXP_OVF_ERR) begin
      errors++;
      $display("FAIL fifo_errcnt: errCount=%0d want %0d", errCount, EXP_OVF_ERR);
    end
    for (int r = 0; r < 16; r++) begin
      wait_cmd("fifo_cmd");
      checks++;
      if (memCmdAddr !== 28'(r) || memCmdWrite !== 1'b0) begin
        errors++;
        $display("FAIL fifo_order%0d: addr=%h write=%b want %h/0", r, memCmdAddr, memCmdWrite, r);
      end
      accept_cmd();
      memRValid = 1'b1;
      for (int b = 0; b < 8; b++) begin
        memRData = 32'(r * 8 + b);
        tick();
        if (b == 0) begin
          checks++;
          if (RDdest !== 4'((r % 15) + 1)) begin
            errors++;
            $display("FAIL fifo_dest%0d: dest=%h want %h", r, RDdest, (r % 15) + 1);
          end
        end
      end
      memRValid = 1'b0;
    end
    repeat (3) tick();
    checks++;
    if (memCmdValid !== 1'b0) begin
      errors++;
      $display("FAIL fifo_drop17: valid=%b want 0 (17th request must be dropped)", memCmdValid);
    end
  endtask

  task automatic test_reset_mid();
    send_slot(4'd2, 32'h10000020, 4'd7);
    wait_cmd("rst_cmd");
    accept_cmd();
    memRValid = 1'b1;
    for (int b = 0; b < 4; b++) begin memRData = 32'hC0 + b; tick(); end
    checks++;
    if (RDdest !== 4'd7) begin
      errors++;
      $display("FAIL rst_pre_dest: dest=%h want 7", RDdest);
    end
    memRData = 32'hC4;
    reset = 1'b0;
    #1;
    checks++;
    if (RDdest !== 4'd0 || RDreturn !== 32'd0 || memCmdValid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: dest=%h ret=%h valid=%b want 0/0/0", RDdest, RDreturn, memCmdValid);
    end
    tick();
    reset = 1'b1;
    for (int b = 5; b < 10; b++) begin
      memRData = 32'hC0 + b;
      tick();
      checks++;
      if (RDdest !== 4'd0 || memCmdValid !== 1'b0) begin
        errors++;
        $display("FAIL rst_after%0d: dest=%h valid=%b want 0/0", b, RDdest, memCmdValid);
      end
    end
    memRValid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    RingIn = '0; SlotTypeIn = 4'd7; SourceIn = '0;
    memCmdReady = 1'b0; memWReady = 1'b0; memRData = '0; memRValid = 1'b0;
    repeat (2) tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_passthrough();
    test_read();
    test_write();
    test_priority();
    test_fifo_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
